serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/control bundle and result/status bundle for the bit-serial adder.
// The master side issues requests; the slave side (the adder) returns results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, sub, cin, A, B,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, sub, cin, A, B,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and one carry flip-flop
// process the operands LSB first, one bit per clock, WIDTH+1 cycles per result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;
    logic             r_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_overflow;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_s;
    logic             w_cNext;
    logic [WIDTH-1:0] w_shifted;

    // The single full-adder cell; the new sum bit enters the accumulator at the MSB end.
    always_comb begin
        w_s       = r_a[0] ^ r_b[0] ^ r_c;
        w_cNext   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
        w_shifted = {w_s, r_acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_count == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the inverted B and forced carry are set up at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_c        <= 1'b0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.A;
            r_b     <= bus.sub ? ~bus.B : bus.B;
            r_c     <= bus.sub | bus.cin;
            r_count <= '0;
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_c     <= w_cNext;
            r_acc   <= w_shifted[WIDTH-1:1];
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_sum      <= w_shifted;
                r_carry    <= w_cNext;
                r_overflow <= r_c ^ w_cNext;
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sum      = r_sum;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the scenario tests
// and a 2-bit instance swept exhaustively against a signed/unsigned reference.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one request for a single cycle; returns at the first falling edge after the start edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        bus8.cin   = c;
        bus8.sub   = s;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic waitDone8(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (bus8.done !== 1'b1 && cycles < 20) begin
            if (bus8.busy === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.overflow} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_w8 got busy=%b done=%b sum=%h carry=%b ovf=%b want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.overflow);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.sum, bus2.carry, bus2.overflow} !== 6'h00) begin
            errors++;
            $display("[TB] FAIL reset_w2 got busy=%b done=%b sum=%h carry=%b ovf=%b want all 0",
                     bus2.busy, bus2.done, bus2.sum, bus2.carry, bus2.overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int cycles;
        int busyCycles;
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (bus8.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_start got %b want 1", bus8.busy);
        end
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 8) begin
            errors++;
            $display("[TB] FAIL add_latency got %0d edges after start edge want 8", cycles);
        end
        checks++;
        if (busyCycles != 8 || bus8.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_busy got %0d cycles, busy in done=%b want 8 and 0", busyCycles, bus8.busy);
        end
        checks++;
        if ({bus8.sum, bus8.carry, bus8.overflow} !== {8'h96, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL add_5A_3C got sum=%h c=%b v=%b want 96 0 1", bus8.sum, bus8.carry, bus8.overflow);
        end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_one_cycle got %b want 0", bus8.done);
        end

        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 8 || {bus8.sum, bus8.carry, bus8.overflow} !== {8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_FF_01_c1 got sum=%h c=%b v=%b lat=%0d want 01 1 0 lat 8",
                     bus8.sum, bus8.carry, bus8.overflow, cycles);
        end
    endtask

    task automatic test_sub();
        int cycles;
        int busyCycles;
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1);
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 8 || {bus8.sum, bus8.carry, bus8.overflow} !== {8'hF0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_10_20 got sum=%h c=%b v=%b lat=%0d want F0 0 0 lat 8",
                     bus8.sum, bus8.carry, bus8.overflow, cycles);
        end
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 8 || {bus8.sum, bus8.carry, bus8.overflow} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sub_80_01 got sum=%h c=%b v=%b lat=%0d want 7F 1 1 lat 8",
                     bus8.sum, bus8.carry, bus8.overflow, cycles);
        end
    endtask

    task automatic test_ignore_start();
        int cycles;
        int busyCycles;
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus8.sum !== 8'h7F || bus8.carry !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_during_shift got sum=%h c=%b want 7F 1", bus8.sum, bus8.carry);
        end
        bus8.start = 1'b1;
        bus8.A     = 8'hAA;
        bus8.B     = 8'h55;
        bus8.sub   = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 5 || {bus8.sum, bus8.carry, bus8.overflow} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ignore_start got sum=%h c=%b v=%b rem=%0d want 02 0 0 rem 5",
                     bus8.sum, bus8.carry, bus8.overflow, cycles);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int busyCycles;
        int donePulses;
        donePulses = 0;
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
        waitDone8(cycles, busyCycles);
        if (bus8.done === 1'b1) donePulses++;
        bus8.start = 1'b1;
        bus8.A     = 8'h10;
        bus8.B     = 8'h20;
        bus8.sub   = 1'b1;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.sum !== 8'h96) begin
            errors++;
            $display("[TB] FAIL b2b_first got busy=%b sum=%h want 0 96", bus8.busy, bus8.sum);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_restart got busy=%b done=%b want 1 0", bus8.busy, bus8.done);
        end
        waitDone8(cycles, busyCycles);
        if (bus8.done === 1'b1) donePulses++;
        checks++;
        if (cycles != 8 || busyCycles != 8 || donePulses != 2 || bus8.sum !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL b2b_second got lat=%0d busy=%0d pulses=%0d sum=%h want 8 8 2 F0",
                     cycles, busyCycles, donePulses, bus8.sum);
        end
    endtask

    task automatic test_reset_mid_op();
        int cycles;
        int busyCycles;
        int doneSeen;
        doneSeen = 0;
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.overflow} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL async_reset got busy=%b done=%b sum=%h c=%b v=%b want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.overflow);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus8.done === 1'b1) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got %0d done cycles want 0", doneSeen);
        end
        applyStimulus(8'h03, 8'h04, 1'b0, 1'b0);
        waitDone8(cycles, busyCycles);
        checks++;
        if (cycles != 8 || {bus8.sum, bus8.carry, bus8.overflow} !== {8'h07, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL after_reset got sum=%h c=%b v=%b lat=%0d want 07 0 0 lat 8",
                     bus8.sum, bus8.carry, bus8.overflow, cycles);
        end
    endtask

    // Reference uses plain integer arithmetic: unsigned sum for carry, signed range for overflow.
    task automatic test_width2_sweep();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 4; a++) begin
                    for (int b = 0; b < 4; b++) begin
                        int         full;
                        int         res;
                        int         sa;
                        int         sb;
                        int         waitCycles;
                        logic [3:0] expVec;
                        logic [3:0] gotVec;
                        sa = (a >= 2) ? a - 4 : a;
                        sb = (b >= 2) ? b - 4 : b;
                        if (s == 0) begin
                            full = a + b + c;
                            res  = sa + sb + c;
                        end else begin
                            full = a + (3 - b) + 1;
                            res  = sa - sb;
                        end
                        expVec = {2'(full & 3), 1'((full >> 2) & 1), 1'((res < -2) || (res > 1))};
                        @(negedge clk);
                        bus2.start = 1'b1;
                        bus2.A     = 2'(a);
                        bus2.B     = 2'(b);
                        bus2.cin   = 1'(c);
                        bus2.sub   = 1'(s);
                        @(negedge clk);
                        bus2.start = 1'b0;
                        waitCycles = 0;
                        while (bus2.done !== 1'b1 && waitCycles < 10) begin
                            @(negedge clk);
                            waitCycles++;
                        end
                        gotVec = {bus2.sum, bus2.carry, bus2.overflow};
                        checks++;
                        if (gotVec !== expVec || waitCycles != 2) begin
                            errors++;
                            $display("[TB] FAIL w2 sub=%0d cin=%0d A=%0d B=%0d got sum/c/v=%b lat=%0d want %b lat 2",
                                     s, c, a, b, gotVec, waitCycles, expVec);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.sub   = 1'b0;
        bus8.cin   = 1'b0;
        bus8.A     = '0;
        bus8.B     = '0;
        bus2.start = 1'b0;
        bus2.sub   = 1'b0;
        bus2.cin   = 1'b0;
        bus2.A     = '0;
        bus2.B     = '0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_width2_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
